// File: rtl/bru_pkg.sv
// Shared constants and helpers for the branch resolve unit.
//   - RV32 opcode[6:2] values for the control-transfer instructions
//   - BRANCH funct3 encodings
//   - 2-bit saturating counter states used by the optional BHT
//   - bht_next(): saturating counter update
package bru_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  // Saturating 2-bit counter step: up on taken, down on not taken.
  function automatic bht_ctr_e bht_next(input bht_ctr_e cur, input logic taken);
    logic [1:0] raw;
    raw = cur;
    if (taken) begin
      return (cur == ST) ? ST : bht_ctr_e'(raw + 2'd1);
    end else begin
      return (cur == SNT) ? SNT : bht_ctr_e'(raw - 2'd1);
    end
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters.
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset (entries reset to WNT)
//   lookup_pc_in        fetch-side lookup PC, indexed by pc[log2(BHT_DEPTH)+1:2]
//   upd_en_in           update strobe (resolved conditional branch leaving the unit)
//   upd_pc_in           PC of the branch being retired into the table
//   upd_taken_in        resolved direction of that branch
//   bht_pred_out        MSB of the looked-up counter (combinational read)
// A read and write to the same index in one cycle returns the pre-update value,
// since the read is taken straight from the registered array.
module bru_bht
  import bru_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] lookup_pc_in,
  input  logic            upd_en_in,
  input  logic [XLEN-1:0] upd_pc_in,
  input  logic            upd_taken_in,
  output logic            bht_pred_out
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  bht_ctr_e            table_q [BHT_DEPTH];
  logic     [IdxW-1:0] lookup_idx;
  logic     [IdxW-1:0] upd_idx;
  logic     [1:0]      rd_ctr;

  assign lookup_idx = lookup_pc_in[IdxW+1:2];
  assign upd_idx    = upd_pc_in[IdxW+1:2];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        table_q[i] <= WNT;
      end
    end else if (upd_en_in) begin
      table_q[upd_idx] <= bht_next(table_q[upd_idx], upd_taken_in);
    end
  end

  assign rd_ctr       = table_q[lookup_idx];
  assign bht_pred_out = rd_ctr[1];

  // Word-offset and high PC bits do not select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_in[XLEN-1:IdxW+2], lookup_pc_in[1:0],
                            upd_pc_in[XLEN-1:IdxW+2], upd_pc_in[1:0]};

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: pipelined (1-cycle) resolution of conditional branches, JAL
// and JALR with target/link generation, mispredict detection against the front-end
// prediction, and retired-branch / mispredict performance counters.
// Optional feature macro: BRU_BHT_EN adds a 2-bit-counter BHT (bru_bht); without it
// bht_pred_out is tied low and bht_pc_in is ignored.
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   valid_in / ready_out            request handshake (ready_out = !valid_out | ready_in)
//   pc_in, rs1_in, rs2_in, imm_in   instruction PC, operands, sign-extended immediate
//   opcode_6_to_2_in, funct3_in     instruction decode fields
//   pred_taken_in, pred_target_in   front-end prediction
//   flush_in                        drop held result and incoming request
//   valid_out / ready_in            result handshake
//   branch_taken_out, target_out    resolved direction and target
//   link_out                        pc+4
//   mispredict_out, redirect_pc_out fetch redirect request and restart PC
//   misaligned_out                  taken target not word aligned (suppresses mispredict)
//   branch_cnt_out                  count of retired conditional branches
//   mispredict_cnt_out              count of retired mispredicts
//   bht_pc_in, bht_pred_out         BHT lookup
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [4:0]       opcode_6_to_2_in,
  input  logic [2:0]       funct3_in,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  input  logic             flush_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             branch_taken_out,
  output logic [XLEN-1:0]  target_out,
  output logic [XLEN-1:0]  link_out,
  output logic             mispredict_out,
  output logic [XLEN-1:0]  redirect_pc_out,
  output logic             misaligned_out,
  output logic [CNT_W-1:0] branch_cnt_out,
  output logic [CNT_W-1:0] mispredict_cnt_out,
  input  logic [XLEN-1:0]  bht_pc_in,
  output logic             bht_pred_out
);

  // ---------------------------------------------------------------------------
  // Resolution (combinational, on the incoming request)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_ltu;
  logic            cond_taken;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_misaligned;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect;
  logic            req_is_branch;

  assign pc_plus4    = pc_in + XLEN'(4);
  assign pc_plus_imm = pc_in + imm_in;
  assign jalr_sum    = rs1_in + imm_in;

  assign cmp_eq  = (rs1_in == rs2_in);
  assign cmp_lt  = ($signed(rs1_in) < $signed(rs2_in));
  assign cmp_ltu = (rs1_in < rs2_in);

  always_comb begin
    cond_taken = 1'b0;
    case (funct3_in)
      F3_BEQ:  cond_taken = cmp_eq;
      F3_BNE:  cond_taken = !cmp_eq;
      F3_BLT:  cond_taken = cmp_lt;
      F3_BGE:  cond_taken = !cmp_lt;
      F3_BLTU: cond_taken = cmp_ltu;
      F3_BGEU: cond_taken = !cmp_ltu;
      default: cond_taken = 1'b0;  // 010/011 are not valid branch conditions
    endcase
  end

  always_comb begin
    res_taken  = 1'b0;
    res_target = pc_plus4;
    case (opcode_6_to_2_in)
      OP_JAL: begin
        res_taken  = 1'b1;
        res_target = pc_plus_imm;
      end
      OP_JALR: begin
        res_taken  = 1'b1;
        res_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BRANCH: begin
        res_taken  = cond_taken;
        res_target = pc_plus_imm;
      end
      default: begin
        res_taken  = 1'b0;
        res_target = pc_plus4;
      end
    endcase
  end

  assign req_is_branch  = (opcode_6_to_2_in == OP_BRANCH);
  assign res_misaligned = res_taken && (res_target[1:0] != 2'b00);
  // A misaligned target goes to the trap path, so no fetch redirect is raised.
  assign res_mispredict = ((res_taken != pred_taken_in) ||
                           (res_taken && (res_target != pred_target_in))) && !res_misaligned;
  assign res_redirect   = res_taken ? res_target : pc_plus4;

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic             valid_q;
  logic             taken_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  link_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_q;
  logic             misaligned_q;
  logic             is_branch_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic             accept;
  logic             retire;

  assign ready_out = !valid_q || ready_in;
  assign accept    = valid_in && ready_out && !flush_in;
  // A flushed result never counts as retired, even if the consumer takes it.
  assign retire    = valid_q && ready_in && !flush_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      misaligned_q <= 1'b0;
      is_branch_q  <= 1'b0;
    end else begin
      if (flush_in) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        taken_q      <= res_taken;
        target_q     <= res_target;
        link_q       <= pc_plus4;
        mispredict_q <= res_mispredict;
        redirect_q   <= res_redirect;
        misaligned_q <= res_misaligned;
        is_branch_q  <= req_is_branch;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (retire) begin
      if (is_branch_q) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict_q) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign valid_out          = valid_q;
  assign branch_taken_out   = taken_q;
  assign target_out         = target_q;
  assign link_out           = link_q;
  assign mispredict_out     = mispredict_q;
  assign redirect_pc_out    = redirect_q;
  assign misaligned_out     = misaligned_q;
  assign branch_cnt_out     = branch_cnt_q;
  assign mispredict_cnt_out = mispredict_cnt_q;

  // ---------------------------------------------------------------------------
  // Optional branch history table
  // ---------------------------------------------------------------------------
`ifdef BRU_BHT_EN
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q <= '0;
    end else if (accept) begin
      pc_q <= pc_in;
    end
  end

  bru_bht #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .lookup_pc_in (bht_pc_in),
    .upd_en_in    (retire && is_branch_q),
    .upd_pc_in    (pc_q),
    .upd_taken_in (taken_q),
    .bht_pred_out (bht_pred_out)
  );
`else
  assign bht_pred_out = 1'b0;

  logic unused_bht;
  assign unused_bht = ^{bht_pc_in, BHT_DEPTH[0]};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic              clk;
  logic              rst_in;
  logic              valid_in;
  logic              ready_out;
  logic [XLEN-1:0]   pc_in, rs1_in, rs2_in, imm_in;
  logic [4:0]        opcode_6_to_2_in;
  logic [2:0]        funct3_in;
  logic              pred_taken_in;
  logic [XLEN-1:0]   pred_target_in;
  logic              flush_in;
  logic              valid_out;
  logic              ready_in;
  logic              branch_taken_out;
  logic [XLEN-1:0]   target_out, link_out, redirect_pc_out;
  logic              mispredict_out, misaligned_out;
  logic [CNT_W-1:0]  branch_cnt_out, mispredict_cnt_out;
  logic [XLEN-1:0]   bht_pc_in;
  logic              bht_pred_out;

  branch_resolve_unit #(
    .XLEN      (XLEN),
    .CNT_W     (CNT_W),
    .BHT_DEPTH (64)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .valid_in           (valid_in),
    .ready_out          (ready_out),
    .pc_in              (pc_in),
    .rs1_in             (rs1_in),
    .rs2_in             (rs2_in),
    .imm_in             (imm_in),
    .opcode_6_to_2_in   (opcode_6_to_2_in),
    .funct3_in          (funct3_in),
    .pred_taken_in      (pred_taken_in),
    .pred_target_in     (pred_target_in),
    .flush_in           (flush_in),
    .valid_out          (valid_out),
    .ready_in           (ready_in),
    .branch_taken_out   (branch_taken_out),
    .target_out         (target_out),
    .link_out           (link_out),
    .mispredict_out     (mispredict_out),
    .redirect_pc_out    (redirect_pc_out),
    .misaligned_out     (misaligned_out),
    .branch_cnt_out     (branch_cnt_out),
    .mispredict_cnt_out (mispredict_cnt_out),
    .bht_pc_in          (bht_pc_in),
    .bht_pred_out       (bht_pred_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_redir;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] tgt, link, redir;
    logic        mp, mis, is_br;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] exp_bcnt = 0;
  logic [31:0] exp_mcnt = 0;
  vec_t        cur;
  vec_t        vecs[13];

  function automatic vec_t mkv(input logic [4:0] op, input logic [2:0] f3,
                               input logic [31:0] pc, rs1, rs2, imm,
                               input logic pt, input logic [31:0] ptgt,
                               input logic et, input logic [31:0] etgt,
                               input logic emp, input logic [31:0] eredir,
                               input logic emis);
    vec_t v;
    v.op = op; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.pt = pt; v.ptgt = ptgt; v.e_taken = et; v.e_tgt = etgt; v.e_mp = emp;
    v.e_redir = eredir; v.e_mis = emis;
    return v;
  endfunction

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.taken = v.e_taken; e.tgt = v.e_tgt; e.mp = v.e_mp; e.redir = v.e_redir;
    e.mis = v.e_mis; e.link = v.pc + 32'd4; e.is_br = (v.op == 5'b11000);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    cur              = v;
    valid_in         = vld;
    opcode_6_to_2_in = v.op;
    funct3_in        = v.f3;
    pc_in            = v.pc;
    rs1_in           = v.rs1;
    rs2_in           = v.rs2;
    imm_in           = v.imm;
    pred_taken_in    = v.pt;
    pred_target_in   = v.ptgt;
  endtask

  // One clock: check at negedge, keep the scoreboard in step, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("branch_cnt", branch_cnt_out, exp_bcnt);
    chk("mispredict_cnt", mispredict_cnt_out, exp_mcnt);
    if (rst_in) begin
      sb.delete();
      exp_bcnt = 0;
      exp_mcnt = 0;
    end else if (flush_in) begin
      if (valid_out && sb.size() > 0) void'(sb.pop_front());
    end else begin
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got unexpected result, want none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("taken", {31'd0, branch_taken_out}, {31'd0, e.taken});
          chk("target", target_out, e.tgt);
          chk("link", link_out, e.link);
          chk("mispredict", {31'd0, mispredict_out}, {31'd0, e.mp});
          chk("redirect", redirect_pc_out, e.redir);
          chk("misaligned", {31'd0, misaligned_out}, {31'd0, e.mis});
          if (e.is_br) exp_bcnt++;
          if (e.mp) exp_mcnt++;
        end
      end
      if (valid_in && ready_out) sb.push_back(expect_of(cur));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v;
  vec_t bht_t, bht_n;
  logic [31:0] base_b, base_m;

  initial begin
    //                op        f3      pc          rs1         rs2  imm         pt ptgt
    //                taken tgt          mp redir        mis
    vecs[0]  = mkv(5'b11000, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 0, 32'h0,
                   1, 32'h120, 1, 32'h120, 0);
    vecs[1]  = mkv(5'b11000, 3'b100, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1, 32'h210,
                   1, 32'h210, 0, 32'h210, 0);
    vecs[2]  = mkv(5'b11000, 3'b110, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1, 32'h210,
                   0, 32'h210, 1, 32'h204, 0);
    vecs[3]  = mkv(5'b11001, 3'b000, 32'h300, 32'h1003, 32'd0, 32'h0, 1, 32'h1002,
                   1, 32'h1002, 0, 32'h1002, 1);
    vecs[4]  = mkv(5'b11011, 3'b000, 32'h400, 32'd0, 32'd0, 32'h6, 0, 32'h0,
                   1, 32'h406, 0, 32'h406, 1);
    vecs[5]  = mkv(5'b11011, 3'b000, 32'h400, 32'd0, 32'd0, 32'hFFFFFFF0, 1, 32'h3F0,
                   1, 32'h3F0, 0, 32'h3F0, 0);
    vecs[6]  = mkv(5'b11000, 3'b001, 32'h500, 32'd3, 32'd3, 32'h8, 0, 32'h0,
                   0, 32'h508, 0, 32'h504, 0);
    vecs[7]  = mkv(5'b11000, 3'b101, 32'h600, 32'h80000000, 32'd0, 32'hC, 1, 32'h60C,
                   0, 32'h60C, 1, 32'h604, 0);
    vecs[8]  = mkv(5'b11000, 3'b111, 32'h700, 32'h80000000, 32'd0, 32'h100, 1, 32'h800,
                   1, 32'h800, 0, 32'h800, 0);
    vecs[9]  = mkv(5'b11000, 3'b010, 32'h900, 32'd1, 32'd2, 32'h40, 0, 32'h0,
                   0, 32'h940, 0, 32'h904, 0);
    vecs[10] = mkv(5'b01100, 3'b000, 32'hA00, 32'd1, 32'd1, 32'h40, 0, 32'h0,
                   0, 32'hA04, 0, 32'hA04, 0);
    vecs[11] = mkv(5'b11001, 3'b000, 32'hB00, 32'hFFFFFFF0, 32'd0, 32'h20, 1, 32'h14,
                   1, 32'h10, 1, 32'h10, 0);
    vecs[12] = mkv(5'b11011, 3'b000, 32'hFFFFFFF8, 32'd0, 32'd0, 32'h10, 1, 32'h8,
                   1, 32'h8, 0, 32'h8, 0);
    idle_v = mkv(5'b00000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0,
                 0, 32'h4, 0, 32'h4, 0);

    rst_in = 1'b1; flush_in = 1'b0; ready_in = 1'b1; bht_pc_in = 32'h40;
    drive(idle_v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_target", target_out, 32'd0);
    chk("rst_link", link_out, 32'd0);
    chk("rst_redirect", redirect_pc_out, 32'd0);
    chk("rst_flags", {29'd0, branch_taken_out, mispredict_out, misaligned_out}, 32'd0);
    chk("rst_bcnt", branch_cnt_out, 32'd0);
    chk("rst_mcnt", mispredict_cnt_out, 32'd0);
    chk("rst_bht", {31'd0, bht_pred_out}, 32'd0);

    // Back-to-back vector stream
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i], 1'b1);
      step();
    end
    drive(idle_v, 1'b0);
    step();
    step();
    chk("table_bcnt", branch_cnt_out, 32'd7);
    chk("table_mcnt", mispredict_cnt_out, 32'd4);

    // Backpressure: hold ready_in low for 3 cycles with a second request waiting
    base_b = exp_bcnt;
    base_m = exp_mcnt;
    ready_in = 1'b0;
    drive(vecs[0], 1'b1);
    step();
    drive(vecs[6], 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", {31'd0, ready_out}, 32'd0);
      chk("hold_valid", {31'd0, valid_out}, 32'd1);
      chk("hold_target", target_out, 32'h120);
      chk("hold_redirect", redirect_pc_out, 32'h120);
      step();
    end
    ready_in = 1'b1;
    step();
    chk("b2b_valid", {31'd0, valid_out}, 32'd1);
    chk("b2b_target", target_out, 32'h508);
    drive(idle_v, 1'b0);
    step();
    step();
    chk("hold_bcnt_plus2", branch_cnt_out, base_b + 32'd2);
    chk("hold_mcnt_plus1", mispredict_cnt_out, base_m + 32'd1);

    // Flush with a held result and a same-cycle request
    base_b = branch_cnt_out;
    base_m = mispredict_cnt_out;
    ready_in = 1'b0;
    drive(vecs[0], 1'b1);
    step();
    flush_in = 1'b1;
    drive(vecs[1], 1'b1);
    step();
    flush_in = 1'b0;
    drive(idle_v, 1'b0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_bcnt", branch_cnt_out, base_b);
    chk("flush_mcnt", mispredict_cnt_out, base_m);
    ready_in = 1'b1;
    step();
    chk("flush_valid2", {31'd0, valid_out}, 32'd0);
    chk("flush_bcnt2", branch_cnt_out, base_b);
    chk("flush_sb_empty", sb.size(), 32'd0);

    // Reset mid-stream with a held result
    ready_in = 1'b0;
    drive(vecs[1], 1'b1);
    step();
    drive(idle_v, 1'b0);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    ready_in = 1'b1;
    chk("mrst_valid", {31'd0, valid_out}, 32'd0);
    chk("mrst_target", target_out, 32'd0);
    chk("mrst_redirect", redirect_pc_out, 32'd0);
    chk("mrst_link", link_out, 32'd0);
    chk("mrst_taken", {31'd0, branch_taken_out}, 32'd0);
    chk("mrst_bcnt", branch_cnt_out, 32'd0);
    chk("mrst_mcnt", mispredict_cnt_out, 32'd0);

    // BHT training at pc=0x40
    bht_t = mkv(5'b11000, 3'b000, 32'h40, 32'd7, 32'd7, 32'h20, 1, 32'h60,
                1, 32'h60, 0, 32'h60, 0);
    bht_n = mkv(5'b11000, 3'b001, 32'h40, 32'd7, 32'd7, 32'h20, 0, 32'h0,
                0, 32'h60, 0, 32'h44, 0);
    bht_pc_in = 32'h40;
    chk("bht_init", {31'd0, bht_pred_out}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(bht_t, 1'b1);
      step();
      drive(idle_v, 1'b0);
      step();
`ifdef BRU_BHT_EN
      chk("bht_taken", {31'd0, bht_pred_out}, 32'd1);
`else
      chk("bht_tied_low", {31'd0, bht_pred_out}, 32'd0);
`endif
    end
    drive(bht_n, 1'b1);
    step();
    drive(idle_v, 1'b0);
    step();
`ifdef BRU_BHT_EN
    chk("bht_st_to_wt", {31'd0, bht_pred_out}, 32'd1);
`else
    chk("bht_tied_low_nt", {31'd0, bht_pred_out}, 32'd0);
`endif
    drive(bht_n, 1'b1);
    step();
    drive(idle_v, 1'b0);
    step();
    chk("bht_wt_to_wnt", {31'd0, bht_pred_out}, 32'd0);
    chk("bht_bcnt", branch_cnt_out, 32'd5);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the combinational branch decision logic in the execute stage. The block:
- resolves conditional branches, JAL and JALR;
- computes the target and link addresses;
- compares the outcome against the front-end prediction and raises a registered redirect on a mispredict;
- keeps retired-branch and mispredict counters.

It sits between execute operand muxing and the fetch redirect path. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- XLEN, 32, data/address width
- CNT_W, 32, performance counter width
- BHT_DEPTH, 64, BHT entries (power of 2, ≥2; used only with BRU_BHT_EN)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- valid_in  in  1  request valid
- ready_out  out  1  block can accept a request
- pc_in, rs1_in, rs2_in, imm_in  in  XLEN each  instruction PC, operands, sign-extended immediate
- opcode_6_to_2_in  in  5  opcode[6:2]
- funct3_in  in  3  funct3
- pred_taken_in  in  1  front-end predicted taken
- pred_target_in  in  XLEN  front-end predicted target
- flush_in  in  1  kill the held result and the incoming request
- valid_out  out  1  result valid
- ready_in  in  1  consumer accepts the result
- branch_taken_out  out  1  resolved taken
- target_out  out  XLEN  resolved target
- link_out  out  XLEN  pc+4
- mispredict_out  out  1  redirect required
- redirect_pc_out  out  XLEN  fetch restart PC
- misaligned_out  out  1  taken target not 4-byte aligned
- branch_cnt_out, mispredict_cnt_out  out  CNT_W each  performance counters
- bht_pc_in  in  XLEN  fetch lookup PC
- bht_pred_out  out  1  BHT prediction

## Operation
Opcode decode:
- 11011 JAL: taken; target = pc+imm.
- 11001 JALR: taken; target = (rs1+imm) & ~1.
- 11000 BRANCH: target = pc+imm; taken by funct3:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010/011 not taken
- Any other opcode: not taken; target = pc+4.

Arithmetic:
- All sums are modulo 2^XLEN.
- Signed compares use two's complement on the full XLEN bits.

Mispredict and redirect:
- mispredict = (taken != pred_taken) | (taken & target != pred_target).
- redirect_pc = taken ? target : pc+4.
- misaligned = taken & (target[1:0] != 0). When misaligned is 1, mispredict_out is forced to 0; the trap path handles it.

Counters, updated on output fire (valid_out & ready_in):
- branch_cnt_out increments for opcode 11000.
- mispredict_cnt_out increments when mispredict_out = 1.
- Both wrap to 0 past 2^CNT_W-1.

Flush:
- flush_in has priority over everything else.
- Next cycle valid_out = 0.
- An input arriving in the same cycle is dropped.
- No counter or BHT update occurs for a flushed result.

## Timing
- Reset values: valid_out 0; all data outputs 0; counters 0; BHT entries 2'b01.
- Input accept = valid_in & ready_out, with ready_out = !valid_out | ready_in (combinational).
- Latency is 1 cycle: a request accepted in cycle N appears on the outputs in N+1.
- Throughput is 1 per cycle when ready_in is held at 1.
- Outputs hold stable while valid_out & !ready_in.
- Reset asserted mid-stream discards the held result; the next cycle matches reset values.

## Configuration
- BRU_BHT_EN defined:
  - Adds a BHT_DEPTH-entry table of 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
  - bht_pred_out = counter[bht_pc_in index][1], read combinationally.
  - Update happens on output fire for opcode 11000 only: increment if taken, decrement if not taken, saturating at 11/00.
  - A same-cycle read and write to the same index returns the old value.
- BRU_BHT_EN undefined:
  - No table is built.
  - bht_pred_out is tied to 0 and bht_pc_in is ignored.
  - Ports remain present.

## Structure
- Package bru_pkg holds:
  - opcode constants (OP_BRANCH 5'b11000, OP_JAL 5'b11011, OP_JALR 5'b11001);
  - funct3 constants;
  - 2-bit counter state encoding (SNT 00, WNT 01, WT 10, ST 11).
- Sub-module bru_bht contains the table, lookup and update logic. It is instantiated only under BRU_BHT_EN.

## Test plan
- BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle branch_taken=1, target=0x120, mispredict=1, redirect_pc=0x120.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, redirect_pc=pc+4.
- JALR with rs1=0x1003, imm=0 and pred_target=0x1002 -> target=0x1002, mispredict=0, misaligned=1 (target[1:0]=10).
- Hold ready_in=0 for 3 cycles with valid_in=1 -> ready_out=0 and outputs stable; raising ready_in then gives back-to-back results and branch_cnt_out +2.
- flush_in asserted together with valid_in while a result is held -> valid_out=0 next cycle and counters unchanged.
- With BRU_BHT_EN: 3 taken branches at pc=0x40 -> the entry goes 01→10→11→11 and bht_pred_out for bht_pc_in=0x40 reads 1 after the first update.
